uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte buffer between the UART receiver and the UART transmitter in loopback and echo designs.
- Accepts byte-valid pulses from the RX stage and stores them in a circular FIFO.
- Drains the FIFO into the TX stage, one byte per transmission, pacing on the transmitter's active/done handshake.
- Removes byte loss when RX bursts arrive while TX is busy, up to DEPTH bytes.

Parameters:
- DEPTH_BITS, 4, log2 of FIFO depth; DEPTH = 2**DEPTH_BITS; legal range 1..8.
- GAP_CYCLES, 1, idle cycles held after i_TX_Done before the next launch; legal range 1..15.

Ports:
- i_Clk  input  1  system clock.
- i_Rst_L  input  1  asynchronous active-low reset.
- i_RX_DV  input  1  one-cycle pulse: i_RX_Byte valid.
- i_RX_Byte  input  8  received byte.
- i_TX_Active  input  1  transmitter busy.
- i_TX_Done  input  1  one-cycle pulse at end of stop bit.
- o_TX_DV  output  1  one-cycle launch pulse to transmitter.
- o_TX_Byte  output  8  byte being transmitted.
- o_Count  output  DEPTH_BITS+1  bytes stored, 0..DEPTH.
- o_Empty  output  1  o_Count == 0.
- o_Full  output  1  o_Count == DEPTH.
- o_Overflow  output  1  sticky dropped-byte flag (see Optional Feature).

Behaviour:
- Reset (async assert, sync release): pointers 0, o_Count 0, o_Empty 1, o_Full 0, o_TX_DV 0, o_TX_Byte 8'h00, o_Overflow 0, FSM in IDLE.
- Reset mid-transmission abandons the in-flight byte and discards all stored bytes.
- Write: on a rising edge with i_RX_DV=1 and o_Full=0, store the byte at wr_ptr and increment wr_ptr mod DEPTH.
- Write when o_Full=1: the byte is dropped, even if a pop occurs in the same cycle.
- Pop: occurs on the IDLE->LAUNCH transition only. Latch mem[rd_ptr] into o_TX_Byte and increment rd_ptr mod DEPTH.
- Simultaneous accepted write and pop: o_Count unchanged.
- o_Count, o_Empty and o_Full are registered and updated on the same edge as the pointer change.
- Pointer wrap: DEPTH-1 -> 0. Full/empty are derived from o_Count, never from pointer equality alone.
- Read FSM states:
  - IDLE: if o_Empty=0 and i_TX_Active=0, go to LAUNCH and pop.
  - LAUNCH: o_TX_DV=1 for exactly this one cycle; next state WAIT_DONE.
  - WAIT_DONE: o_TX_DV=0; stay until i_TX_Done=1, then go to GAP and load the gap counter with GAP_CYCLES-1.
  - GAP: decrement the counter; go to IDLE when it reads 0.
- o_TX_Byte is held stable from LAUNCH until the next pop.
- i_TX_Done outside WAIT_DONE is ignored.
- Latency: byte written into an empty FIFO with FSM in IDLE and TX idle -> o_TX_DV high at edge N+2, where N is the edge sampling i_RX_DV.
- Back-to-back launch spacing: i_TX_Done edge + GAP_CYCLES + 2 edges.
- No watchdog. If i_TX_Done never arrives, the FSM stays in WAIT_DONE; writes continue until full.

Optional Feature:
- Macro: UART_TX_FIFO_OVERFLOW_EN.
- Defined: o_Overflow is set on the edge where a write is dropped because the FIFO is full. It stays set until reset and is unaffected by subsequent pops.
- Not defined: o_Overflow is driven constant 0 and no overflow logic is synthesised. Drop-on-full behaviour is unchanged.

Test Plan:
- Reset check: i_Rst_L=0, then released -> o_Count=0, o_Empty=1, o_Full=0, o_TX_DV=0, o_TX_Byte=8'h00, o_Overflow=0.
- Single byte: RX pulse 8'hA5 at edge N, TX model idle -> o_TX_DV=1 at edge N+2 only, o_TX_Byte=8'hA5, o_Count returns to 0 at N+2.
- Burst with TX model (217 clks/bit): 5 RX pulses 8'h31..8'h35 while TX active -> five launches in order 31,32,33,34,35. Each launch follows i_TX_Done by GAP_CYCLES+2 edges; o_Count peaks at 4.
- Overflow and wrap (DEPTH_BITS=4, i_TX_Active held 1): write 17 bytes 8'h00..8'h10 -> o_Full=1 after the 16th, o_Count=16, byte 8'h10 dropped, o_Overflow=1 (macro on) or 0 (macro off). Release TX -> output 00..0F, wrapping rd_ptr to 0.
- Simultaneous write/pop: write on the exact IDLE->LAUNCH edge with o_Count=3 -> o_Count stays 3, the popped byte is the oldest.
- Reset mid-transmission: assert i_Rst_L in WAIT_DONE with o_Count=2 -> all outputs at reset values immediately (asynchronous). After release, no o_TX_DV without new RX input.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a UART receiver and transmitter, draining one byte per TX frame.
// Optional sticky drop flag: define UART_TX_FIFO_OVERFLOW_EN to enable o_Overflow.
module uart_tx_fifo #(
   parameter int DEPTH_BITS = 4,
   parameter int GAP_CYCLES = 1
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst_L,
   input  logic                  i_RX_DV,
   input  logic [7:0]            i_RX_Byte,
   input  logic                  i_TX_Active,
   input  logic                  i_TX_Done,
   output logic                  o_TX_DV,
   output logic [7:0]            o_TX_Byte,
   output logic [DEPTH_BITS:0]   o_Count,
   output logic                  o_Empty,
   output logic                  o_Full,
   output logic                  o_Overflow
);

   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS-1:0] PTR_ONE   = 1;
   localparam logic [DEPTH_BITS:0]   CNT_ONE   = 1;
   localparam logic [DEPTH_BITS:0]   CNT_DEPTH = (DEPTH_BITS+1)'(DEPTH);
   localparam logic [3:0]            GAP_LOAD  = 4'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   logic [7:0]            r_mem [DEPTH];
   logic [DEPTH_BITS-1:0] r_wr_ptr;
   logic [DEPTH_BITS-1:0] r_rd_ptr;
   logic [DEPTH_BITS:0]   r_count;
   logic                  r_empty;
   logic                  r_full;
   logic [7:0]            r_tx_byte;
   logic [3:0]            r_gap_cnt;
   state_t                r_state;

   state_t                w_state_nxt;
   logic [3:0]            w_gap_cnt_nxt;
   logic                  w_wr;
   logic                  w_pop;
   logic [DEPTH_BITS:0]   w_count_nxt;

   // A full FIFO drops the write even when a pop frees a slot on the same edge.
   assign w_wr = i_RX_DV & ~r_full;

   always_comb begin
      w_state_nxt   = r_state;
      w_gap_cnt_nxt = r_gap_cnt;
      w_pop         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!r_empty && !i_TX_Active) begin
               w_state_nxt = S_LAUNCH;
               w_pop       = 1'b1;
            end
         end
         S_LAUNCH: w_state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (i_TX_Done) begin
               w_state_nxt   = S_GAP;
               w_gap_cnt_nxt = GAP_LOAD;
            end
         end
         S_GAP: begin
            if (r_gap_cnt == 4'd0) w_state_nxt = S_IDLE;
            else                   w_gap_cnt_nxt = r_gap_cnt - 4'd1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_ONE;
         2'b01:   w_count_nxt = r_count - CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_state   <= S_IDLE;
         r_gap_cnt <= 4'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_gap_cnt <= w_gap_cnt_nxt;
      end
   end

   // Flags are registered from the next count so they move with the pointers.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_empty   <= 1'b1;
         r_full    <= 1'b0;
         r_tx_byte <= 8'h00;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + PTR_ONE;
            r_tx_byte <= r_mem[r_rd_ptr];
         end
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == CNT_DEPTH);
      end
   end

   always_ff @(posedge i_Clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_RX_Byte;
   end

`ifdef UART_TX_FIFO_OVERFLOW_EN
   logic r_overflow;

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L)             r_overflow <= 1'b0;
      else if (i_RX_DV && r_full) r_overflow <= 1'b1;
   end

   assign o_Overflow = r_overflow;
`else
   assign o_Overflow = 1'b0;
`endif

   assign o_TX_DV   = (r_state == S_LAUNCH);
   assign o_TX_Byte = r_tx_byte;
   assign o_Count   = r_count;
   assign o_Empty   = r_empty;
   assign o_Full    = r_full;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: queue reference model plus a frame-level TX model.
module tb_uart_tx_fifo;

   localparam int DB    = 4;
   localparam int DEPTH = 1 << DB;
   localparam int GAP   = 3;
`ifdef UART_TX_FIFO_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         rx_dv = 1'b0;
   logic [7:0]   rx_byte = 8'h00;
   logic         tx_active;
   logic         tx_done = 1'b0;
   logic         tx_force = 1'b1;
   int           tx_busy = 0;
   int           frame_len = 20;
   logic         tx_dv;
   logic [7:0]   tx_byte;
   logic [DB:0]  count;
   logic         empty, full, ovf_o;

   uart_tx_fifo #(.DEPTH_BITS(DB), .GAP_CYCLES(GAP)) dut (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte),
      .i_TX_Active(tx_active), .i_TX_Done(tx_done),
      .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte), .o_Count(count),
      .o_Empty(empty), .o_Full(full), .o_Overflow(ovf_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Transmitter model: busy for frame_len cycles after a launch, then a one-cycle done.
   assign tx_active = tx_force || (tx_busy > 0);

   always @(negedge clk) begin
      if (!rst_n) begin
         tx_busy = 0;
         tx_done = 1'b0;
      end else begin
         tx_done = 1'b0;
         if (tx_dv) tx_busy = frame_len;
         else if (tx_busy > 0) begin
            tx_busy--;
            if (tx_busy == 0) tx_done = 1'b1;
         end
      end
   end

   // Reference model: byte queue, in-flight flag and the earliest edge a launch may happen.
   logic [7:0]  q[$];
   logic [7:0]  launched[$];
   bit          in_flight = 1'b0;
   bit          m_ovf = 1'b0;
   int          cyc = 0;
   int          launch_edge = 0;
   int          ready_edge = 0;
   logic        m_dv, m_act, m_done, m_exp;
   logic [7:0]  m_b;
   int          m_pre;

   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete();
         in_flight   = 1'b0;
         m_ovf       = 1'b0;
         ready_edge  = 0;
      end else begin
         cyc++;
         m_dv   = rx_dv;
         m_b    = rx_byte;
         m_act  = tx_active;
         m_done = tx_done;
         m_pre  = q.size();
         m_exp  = (m_pre > 0) && !m_act && !in_flight && (cyc >= ready_edge);
         #1;
         chk("launch", tx_dv, m_exp);
         if (tx_dv) begin
            if (q.size() > 0) begin
               chk("tx_byte", tx_byte, q[0]);
               void'(q.pop_front());
            end
            launched.push_back(tx_byte);
            in_flight   = 1'b1;
            launch_edge = cyc;
         end else if (m_done && in_flight && cyc >= launch_edge + 2) begin
            // Launch becomes visible after edge done+GAP+1, i.e. is sampled GAP+2 edges after done.
            in_flight  = 1'b0;
            ready_edge = cyc + GAP + 1;
         end
         if (m_dv) begin
            if (m_pre == DEPTH) m_ovf = 1'b1;
            else                q.push_back(m_b);
         end
         chk("count", count, q.size());
         chk("empty", empty, q.size() == 0);
         chk("full", full, q.size() == DEPTH);
         chk("overflow", ovf_o, OVF_EN & m_ovf);
      end
   end

   task automatic send(input logic [7:0] b);
      rx_dv = 1'b1;
      rx_byte = b;
      @(negedge clk);
      rx_dv = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while ((q.size() != 0 || in_flight || tx_busy != 0 || cyc < ready_edge) && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("drain_timeout", k < budget, 1'b1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_count"}, count, 0);
      chk({tag, "_empty"}, empty, 1);
      chk({tag, "_full"}, full, 0);
      chk({tag, "_txdv"}, tx_dv, 0);
      chk({tag, "_txbyte"}, tx_byte, 8'h00);
      chk({tag, "_ovf"}, ovf_o, 0);
   endtask

   initial begin
      int base;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst_hold");
      rst_n = 1'b1;
      tx_force = 1'b0;
      @(negedge clk);
      chk_reset_vals("rst_rel");

      // Single byte: launch visible right after edge N+1, sampled by TX at N+2.
      frame_len = 20;
      send(8'hA5);
      @(posedge clk); #2;
      chk("single_dv", tx_dv, 1);
      chk("single_byte", tx_byte, 8'hA5);
      chk("single_cnt", count, 0);
      @(posedge clk); #2;
      chk("single_dv_off", tx_dv, 0);
      @(negedge clk);
      wait_drain(200);

      // Burst against a 217 clk/bit, 10-bit frame transmitter.
      frame_len = 2170;
      base = launched.size();
      send(8'h31);
      repeat (3) @(negedge clk);
      for (int i = 2; i <= 5; i++) send(8'h30 + 8'(i));
      chk("burst_peak", count, 4);
      wait_drain(20000);
      chk("burst_n", launched.size() - base, 5);
      for (int i = 0; i < 5; i++) chk("burst_order", launched[base+i], 8'h31 + 8'(i));

      // Overflow and pointer wrap with TX held busy.
      frame_len = 6;
      tx_force = 1'b1;
      base = launched.size();
      for (int i = 0; i <= 16; i++) send(8'(i));
      chk("ovf_full", full, 1);
      chk("ovf_cnt", count, 16);
      chk("ovf_flag", ovf_o, OVF_EN);
      tx_force = 1'b0;
      wait_drain(2000);
      chk("wrap_n", launched.size() - base, 16);
      for (int i = 0; i < 16; i++) chk("wrap_order", launched[base+i], 8'(i));
      chk("ovf_sticky", ovf_o, OVF_EN);

      // Write on the exact pop edge with three bytes stored.
      tx_force = 1'b1;
      send(8'h50); send(8'h51); send(8'h52);
      chk("simul_pre", count, 3);
      tx_force = 1'b0;
      rx_dv = 1'b1;
      rx_byte = 8'h53;
      @(posedge clk); #2;
      chk("simul_dv", tx_dv, 1);
      chk("simul_byte", tx_byte, 8'h50);
      chk("simul_cnt", count, 3);
      @(negedge clk);
      rx_dv = 1'b0;
      wait_drain(2000);

      // Asynchronous reset while waiting for done with two bytes stored.
      frame_len = 200;
      tx_force = 1'b1;
      send(8'h61); send(8'h62); send(8'h63);
      tx_force = 1'b0;
      repeat (10) @(negedge clk);
      chk("midrst_cnt", count, 2);
      chk("midrst_busy", tx_active, 1);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midrst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      base = launched.size();
      repeat (30) @(negedge clk);
      chk("midrst_quiet", launched.size() - base, 0);

      // Random traffic with random frame lengths.
      for (int c = 0; c < 800; c++) begin
         rx_dv = ($urandom_range(0, 3) == 0);
         rx_byte = 8'($urandom);
         frame_len = $urandom_range(2, 25);
         @(negedge clk);
      end
      rx_dv = 1'b0;
      wait_drain(5000);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
